perceptron_weight_store: RTL and testbench
==========================================

Name: perceptron_weight_store

Overview:
Second-generation perceptron weight storage for the neural branch predictor. It adds the following on top of plain row storage:
- a registered prediction read port;
- an in-block training engine that applies saturating +1/-1 updates to a whole row via a pipelined read-modify-write, with same-address forwarding;
- a post-reset zeroing sweep.

It sits between the predictor front-end (row fetch for dot product) and the branch-resolution logic (training requests).

Parameters:
NUM_PERCEPTRONS, 128, number of rows (perceptrons)
HISTORY_LENGTH, 32, global history bits per row; the row holds HISTORY_LENGTH+1 weights (index 0 = bias)
WEIGHT_WIDTH, 8, signed two's-complement width of each weight
ADDR_WIDTH, $clog2(NUM_PERCEPTRONS), row index width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
rd_en  input  1  prediction read request
rd_addr  input  ADDR_WIDTH  row to read
rd_valid  output  1  rd_weights valid this cycle
rd_weights  output  (HISTORY_LENGTH+1)*WEIGHT_WIDTH  packed row; weight i at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
tr_valid  input  1  training request
tr_ready  output  1  block accepts a training request this cycle
tr_addr  input  ADDR_WIDTH  row to train
tr_hist  input  HISTORY_LENGTH  history used at prediction; bit j pairs with weight j+1
tr_taken  input  1  resolved outcome
init_done  output  1  zeroing sweep complete

Behaviour:
- Reset: clk/rst as decided (one clock, async active-high). While rst is high:
  - rd_valid=0, rd_weights=0, tr_ready=0, init_done=0.
  - FSM=INIT, sweep counter=0, pipeline stage S1 invalid.
- FSM INIT:
  - Each cycle writes an all-zero row at the sweep counter, then increments it.
  - After writing row NUM_PERCEPTRONS-1: go to RUN. init_done=1 and tr_ready=1 from the next cycle.
  - Sweep takes exactly NUM_PERCEPTRONS cycles after rst deasserts.
  - rd_en and tr_valid are ignored in INIT; rd_valid stays 0.
- FSM RUN:
  - tr_ready=1 permanently; no backpressure.
  - RUN→INIT only via rst.
- Read port:
  - rd_en at cycle T gives rd_valid=1 and rd_weights=row(rd_addr) at T+1.
  - rd_valid=0 in cycles without a request; rd_weights holds its last value.
  - Write-first: if the S1 commit in cycle T targets rd_addr, the returned row is the newly committed value.
- Training pipeline (2 stages):
  - Accept at T when tr_valid && tr_ready. Capture addr, hist, taken and the old row into S1.
  - Old row forwarding: if S1 is valid at T with the same addr, use S1's updated row instead of memory.
  - During T+1, S1 computes the new row. It is written to memory at the end of T+1.
  - Back-to-back requests (one per cycle) to the same row accumulate correctly.
- Update rule:
  - t = +1 if tr_taken, else -1.
  - Bias: w0 ← sat(w0 + t).
  - For j in 0..HISTORY_LENGTH-1: x = +1 if tr_hist[j], else -1; w(j+1) ← sat(w(j+1) + t·x).
  - sat clamps to [-(2^(WEIGHT_WIDTH-1)), 2^(WEIGHT_WIDTH-1)-1]. Compute at WEIGHT_WIDTH+1 bits, then clamp; never wrap.
- Simultaneous read and train to the same row in the same cycle: the read returns the pre-update row. The update is visible to reads issued from T+1 onward (write-first at T+1).
- Reset mid-operation: any pending S1 write is dropped, the in-progress output is cleared, and the sweep restarts from row 0.

Decomposition:
- perceptron_pkg holds:
  - typedefs weight_t (signed [WEIGHT_WIDTH-1:0]) and row_t (weight_t array [HISTORY_LENGTH:0]);
  - constants W_MAX and W_MIN;
  - FSM state enum {INIT, RUN}.
- One combinational sub-module, perceptron_sat_update (row, hist, taken → new row), instantiated once in S1. The top level owns the FSM, memory, forwarding and read register.

Test Plan (bench: NUM_PERCEPTRONS=8, HISTORY_LENGTH=4, WEIGHT_WIDTH=8):
1. Release rst → tr_ready=0 and init_done=0 for exactly 8 cycles, then both 1. rd_en of every row → all weights 0, each with rd_valid one cycle after its request.
2. Train row 3, hist=4'b0101, taken=1 → two cycles later reading row 3 returns w0..w4 = {+1, +1, -1, +1, -1}.
3. 130 consecutive trains of row 5, hist=4'b1111, taken=1 → every weight saturates at +127. Then 260 trains with taken=1, hist=0 → w0=+127, w1..w4=-128; no wrap.
4. Back-to-back trains of row 2 on 3 consecutive cycles, hist=0, taken=0 → row 2 reads {-3, +3, +3, +3, +3}; forwarding proven, no lost update.
5. Read row 2 in the same cycle a train of row 2 is accepted → old row returned. Read issued the next cycle → updated row (write-first).
6. Assert rst for 1 cycle while a train is in S1 → rd_valid=0, init_done=0, and after the 8-cycle sweep the row reads all zeros.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared types and FSM encoding for the perceptron weight store and its update datapath.
// Types here describe the default geometry; modules size their own rows from parameters.
package perceptron_pkg;

    localparam int DEF_HISTORY_LENGTH = 32;
    localparam int DEF_WEIGHT_WIDTH   = 8;

    typedef logic signed [DEF_WEIGHT_WIDTH-1:0] weight_t;
    typedef weight_t row_t [DEF_HISTORY_LENGTH:0];

    localparam weight_t W_MAX = {1'b0, {(DEF_WEIGHT_WIDTH-1){1'b1}}};
    localparam weight_t W_MIN = {1'b1, {(DEF_WEIGHT_WIDTH-1){1'b0}}};

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/perceptron_sat_update.sv
// Combinational training rule: every weight of a row moves one step toward agreement
// with the outcome, clamped to the signed weight range instead of wrapping.
module perceptron_sat_update
    import perceptron_pkg::*;
#(
    parameter int HISTORY_LENGTH = 32,
    parameter int WEIGHT_WIDTH   = 8
) (
    input  logic [(HISTORY_LENGTH+1)*WEIGHT_WIDTH-1:0] i_row,
    input  logic [HISTORY_LENGTH-1:0]                  i_hist,
    input  logic                                       i_taken,
    output logic [(HISTORY_LENGTH+1)*WEIGHT_WIDTH-1:0] o_row
);

    localparam logic signed [WEIGHT_WIDTH-1:0] LW_MAX = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
    localparam logic signed [WEIGHT_WIDTH-1:0] LW_MIN = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};

    // One extra bit of headroom exposes overflow as a mismatch of the top two sum bits.
    function automatic logic signed [WEIGHT_WIDTH-1:0] sat_step(
        input logic signed [WEIGHT_WIDTH-1:0] w,
        input logic                           up
    );
        logic [WEIGHT_WIDTH:0] s;
        s = {w[WEIGHT_WIDTH-1], w} + (up ? (WEIGHT_WIDTH+1)'(1) : {(WEIGHT_WIDTH+1){1'b1}});
        if (s[WEIGHT_WIDTH] && !s[WEIGHT_WIDTH-1]) begin
            return LW_MIN;
        end else if (!s[WEIGHT_WIDTH] && s[WEIGHT_WIDTH-1]) begin
            return LW_MAX;
        end else begin
            return s[WEIGHT_WIDTH-1:0];
        end
    endfunction

    always_comb begin
        o_row = '0;
        o_row[0 +: WEIGHT_WIDTH] = sat_step(i_row[0 +: WEIGHT_WIDTH], i_taken);
        for (int j = 0; j < HISTORY_LENGTH; j++) begin
            o_row[(j+1)*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
                sat_step(i_row[(j+1)*WEIGHT_WIDTH +: WEIGHT_WIDTH], !(i_taken ^ i_hist[j]));
        end
    end

endmodule

// File: rtl/perceptron_weight_store.sv
// Perceptron row storage with registered prediction reads, a two-stage saturating
// training pipeline with same-row forwarding, and a post-reset zeroing sweep.
module perceptron_weight_store
    import perceptron_pkg::*;
#(
    parameter int NUM_PERCEPTRONS = 128,
    parameter int HISTORY_LENGTH  = 32,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int ADDR_WIDTH      = $clog2(NUM_PERCEPTRONS)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       rd_en,
    input  logic [ADDR_WIDTH-1:0]                      rd_addr,
    output logic                                       rd_valid,
    output logic [(HISTORY_LENGTH+1)*WEIGHT_WIDTH-1:0] rd_weights,
    input  logic                                       tr_valid,
    output logic                                       tr_ready,
    input  logic [ADDR_WIDTH-1:0]                      tr_addr,
    input  logic [HISTORY_LENGTH-1:0]                  tr_hist,
    input  logic                                       tr_taken,
    output logic                                       init_done
);

    localparam int ROW_W = (HISTORY_LENGTH+1)*WEIGHT_WIDTH;

    logic [ROW_W-1:0]          r_mem [NUM_PERCEPTRONS];
    logic [0:0]                r_state;
    logic [ADDR_WIDTH-1:0]     r_sweep;
    logic                      r_rd_valid;
    logic [ROW_W-1:0]          r_rd_weights;

    logic                      r_vld_p1;
    logic [ADDR_WIDTH-1:0]     r_addr_p1;
    logic [HISTORY_LENGTH-1:0] r_hist_p1;
    logic                      r_taken_p1;
    logic [ROW_W-1:0]          r_row_p1;

    logic                      w_run;
    logic                      w_accept_p0;
    logic [ROW_W-1:0]          w_old_row_p0;
    logic [ROW_W-1:0]          w_new_row_p1;
    logic [ROW_W-1:0]          w_rd_row;

    assign w_run       = (r_state == ST_RUN);
    assign w_accept_p0 = tr_valid && w_run;

    // The row still in S1 has not reached memory yet, so it supersedes the stored copy.
    assign w_old_row_p0 = (r_vld_p1 && (r_addr_p1 == tr_addr)) ? w_new_row_p1 : r_mem[tr_addr];
    assign w_rd_row     = (r_vld_p1 && (r_addr_p1 == rd_addr)) ? w_new_row_p1 : r_mem[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_sweep    <= '0;
            r_vld_p1   <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_vld_p1   <= w_accept_p0;
            r_rd_valid <= rd_en && w_run;
            if (r_state == ST_INIT) begin
                r_sweep <= r_sweep + 1'b1;
                if (r_sweep == ADDR_WIDTH'(NUM_PERCEPTRONS-1)) begin
                    r_state <= ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_weights <= '0;
        end else if (rd_en && w_run) begin
            r_rd_weights <= w_rd_row;
        end
    end

    // p0 -> p1: capture the request and the (possibly forwarded) old row
    always_ff @(posedge clk) begin
        if (w_accept_p0) begin
            r_addr_p1  <= tr_addr;
            r_hist_p1  <= tr_hist;
            r_taken_p1 <= tr_taken;
            r_row_p1   <= w_old_row_p0;
        end
    end

    perceptron_sat_update #(
        .HISTORY_LENGTH(HISTORY_LENGTH),
        .WEIGHT_WIDTH  (WEIGHT_WIDTH)
    ) u_sat_update (
        .i_row  (r_row_p1),
        .i_hist (r_hist_p1),
        .i_taken(r_taken_p1),
        .o_row  (w_new_row_p1)
    );

    // p1 -> memory: sweep writes during INIT, committed training rows during RUN
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_sweep] <= '0;
        end else if (r_vld_p1) begin
            r_mem[r_addr_p1] <= w_new_row_p1;
        end
    end

    assign rd_valid   = r_rd_valid;
    assign rd_weights = r_rd_weights;
    assign tr_ready   = w_run;
    assign init_done  = w_run;

endmodule

// File: tb/tb_perceptron_weight_store.sv
// Bench for perceptron_weight_store: directed scenarios plus random traffic checked
// against an integer model that applies each accepted training step atomically.
module tb_perceptron_weight_store;

    localparam int NP = 8;
    localparam int HL = 4;
    localparam int WW = 8;
    localparam int AW = 3;
    localparam int RW = (HL+1)*WW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [RW-1:0] rd_weights;
    logic          tr_valid = 1'b0;
    logic          tr_ready;
    logic [AW-1:0] tr_addr = '0;
    logic [HL-1:0] tr_hist = '0;
    logic          tr_taken = 1'b0;
    logic          init_done;

    int            checks = 0;
    int            errors = 0;
    int            model [NP][HL+1];
    logic [RW-1:0] exp_row;
    logic          exp_vld;

    perceptron_weight_store #(
        .NUM_PERCEPTRONS(NP),
        .HISTORY_LENGTH (HL),
        .WEIGHT_WIDTH   (WW),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_weights(rd_weights),
        .tr_valid  (tr_valid),
        .tr_ready  (tr_ready),
        .tr_addr   (tr_addr),
        .tr_hist   (tr_hist),
        .tr_taken  (tr_taken),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic logic [RW-1:0] pack_row(input int a);
        logic [RW-1:0] r;
        int            v;
        r = '0;
        for (int i = 0; i <= HL; i++) begin
            v = model[a][i];
            r[i*WW +: WW] = v[WW-1:0];
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int a = 0; a < NP; a++)
            for (int i = 0; i <= HL; i++)
                model[a][i] = 0;
    endtask

    task automatic apply_train(input int a, input logic [HL-1:0] h, input logic tk);
        int t;
        int x;
        t = tk ? 1 : -1;
        model[a][0] = clamp(model[a][0] + t);
        for (int j = 0; j < HL; j++) begin
            x = h[j] ? 1 : -1;
            model[a][j+1] = clamp(model[a][j+1] + t * x);
        end
    endtask

    // Drives one cycle; the expected read is the model before this cycle's own train.
    task automatic drive_cycle(input logic ren, input logic [AW-1:0] ra, input logic tv,
                               input logic [AW-1:0] ta, input logic [HL-1:0] h, input logic tk);
        logic rdy;
        rd_en    = ren;
        rd_addr  = ra;
        tr_valid = tv;
        tr_addr  = ta;
        tr_hist  = h;
        tr_taken = tk;
        rdy      = tr_ready;
        exp_vld  = ren && rdy;
        if (exp_vld) exp_row = pack_row(int'(ra));
        if (tv && rdy) apply_train(int'(ta), h, tk);
        @(posedge clk);
        #1;
        rd_en    = 1'b0;
        tr_valid = 1'b0;
    endtask

    task automatic wait_sweep(input string name);
        int n;
        n = 0;
        while (tr_ready !== 1'b1 && n < 20) begin
            rd_en    = 1'b1;
            rd_addr  = AW'($urandom_range(0, NP-1));
            tr_valid = 1'b1;
            tr_addr  = AW'($urandom_range(0, NP-1));
            tr_hist  = HL'($urandom);
            tr_taken = 1'(($urandom));
            @(posedge clk);
            #1;
            n++;
            checks++;
            if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s rd_valid_during_sweep got %b expected 0", name, rd_valid);
            end
        end
        rd_en    = 1'b0;
        tr_valid = 1'b0;
        checks++;
        if (n != NP) begin
            errors++;
            $display("FAIL %s sweep_cycles got %0d expected %0d", name, n, NP);
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL %s init_done got %b expected 1", name, init_done);
        end
        clear_model();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset rd_valid got %b expected 0", rd_valid); end
        checks++;
        if (rd_weights !== '0) begin errors++; $display("FAIL reset rd_weights got %h expected 0", rd_weights); end
        checks++;
        if (tr_ready !== 1'b0) begin errors++; $display("FAIL reset tr_ready got %b expected 0", tr_ready); end
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL reset init_done got %b expected 0", init_done); end
        rst = 1'b0;
        wait_sweep("init");
        for (int a = 0; a < NP; a++) begin
            drive_cycle(1'b1, AW'(a), 1'b0, '0, '0, 1'b0);
            checks++;
            if (rd_valid !== 1'b1 || rd_weights !== '0) begin
                errors++;
                $display("FAIL init_read row %0d got vld=%b %h expected vld=1 0", a, rd_valid, rd_weights);
            end
        end
        drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL idle rd_valid got %b expected 0", rd_valid); end
    endtask

    task automatic test_single_train();
        drive_cycle(1'b0, '0, 1'b1, AW'(3), 4'b0101, 1'b1);
        drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0);
        drive_cycle(1'b1, AW'(3), 1'b0, '0, '0, 1'b0);
        checks++;
        if (rd_valid !== 1'b1 || rd_weights !== 40'hFF_01_FF_01_01) begin
            errors++;
            $display("FAIL single_train got vld=%b %h expected vld=1 ff01ff0101", rd_valid, rd_weights);
        end
        checks++;
        if (rd_weights !== exp_row) begin
            errors++;
            $display("FAIL single_train_model got %h expected %h", rd_weights, exp_row);
        end
    endtask

    task automatic test_saturation();
        repeat (130) drive_cycle(1'b0, '0, 1'b1, AW'(5), 4'b1111, 1'b1);
        drive_cycle(1'b1, AW'(5), 1'b0, '0, '0, 1'b0);
        checks++;
        if (rd_weights !== 40'h7F_7F_7F_7F_7F) begin
            errors++;
            $display("FAIL sat_high got %h expected 7f7f7f7f7f", rd_weights);
        end
        repeat (260) drive_cycle(1'b0, '0, 1'b1, AW'(5), 4'b0000, 1'b1);
        drive_cycle(1'b1, AW'(5), 1'b0, '0, '0, 1'b0);
        checks++;
        if (rd_weights !== 40'h80_80_80_80_7F) begin
            errors++;
            $display("FAIL sat_low got %h expected 808080807f", rd_weights);
        end
    endtask

    task automatic test_back_to_back();
        repeat (3) drive_cycle(1'b0, '0, 1'b1, AW'(2), 4'b0000, 1'b0);
        drive_cycle(1'b1, AW'(2), 1'b0, '0, '0, 1'b0);
        checks++;
        if (rd_weights !== 40'h03_03_03_03_FD) begin
            errors++;
            $display("FAIL back_to_back got %h expected 03030303fd", rd_weights);
        end
    endtask

    task automatic test_read_during_train();
        drive_cycle(1'b1, AW'(2), 1'b1, AW'(2), 4'b0000, 1'b0);
        checks++;
        if (rd_valid !== 1'b1 || rd_weights !== 40'h03_03_03_03_FD) begin
            errors++;
            $display("FAIL same_cycle_read got vld=%b %h expected vld=1 03030303fd", rd_valid, rd_weights);
        end
        drive_cycle(1'b1, AW'(2), 1'b0, '0, '0, 1'b0);
        checks++;
        if (rd_weights !== 40'h04_04_04_04_FC) begin
            errors++;
            $display("FAIL write_first_read got %h expected 04040404fc", rd_weights);
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, AW'(2), 1'b1, AW'(1), HL'($urandom), 1'b1);
        checks++;
        if (rd_weights !== 40'h04_04_04_04_FC) begin
            errors++;
            $display("FAIL pre_reset_read got %h expected 04040404fc", rd_weights);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_weights !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got vld=%b %h expected vld=0 0", rd_valid, rd_weights);
        end
        checks++;
        if (init_done !== 1'b0 || tr_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl got done=%b ready=%b expected 0 0", init_done, tr_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_sweep("mid_reset");
        for (int a = 1; a <= 2; a++) begin
            drive_cycle(1'b1, AW'(a), 1'b0, '0, '0, 1'b0);
            checks++;
            if (rd_valid !== 1'b1 || rd_weights !== '0) begin
                errors++;
                $display("FAIL post_reset_row %0d got vld=%b %h expected vld=1 0", a, rd_valid, rd_weights);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            drive_cycle(1'($urandom), AW'($urandom_range(0, 3)),
                        1'($urandom), AW'($urandom_range(0, 3)),
                        HL'($urandom), 1'($urandom));
            checks++;
            if (exp_vld) begin
                if (rd_valid !== 1'b1 || rd_weights !== exp_row) begin
                    errors++;
                    $display("FAIL random cycle %0d got vld=%b %h expected vld=1 %h", k, rd_valid, rd_weights, exp_row);
                end
            end else if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL random cycle %0d rd_valid got %b expected 0", k, rd_valid);
            end
        end
    endtask

    initial begin
        exp_row = '0;
        exp_vld = 1'b0;
        clear_model();
        test_reset();
        test_single_train();
        test_saturation();
        test_back_to_back();
        test_read_during_train();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
